// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex display scan driver with a double-buffered display register.
// Optional leading-zero blanking is enabled by defining HEX_LZB_EN.
module hex_scan_driver #(
    parameter int NUM_DIGITS = 2,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    output logic [3:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);

    typedef enum logic {EMPTY, SCAN} state_t;

    state_t                  state_q, state_d;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DW-1:0]           disp_q, disp_d;
    logic [DW-1:0]           shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic [3:0]              nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    frame_done_q, frame_done_d;

    logic tick;
    logic last_digit;
    logic wrap;
    logic [NUM_DIGITS-1:0] lit;

`ifdef HEX_LZB_EN
    logic [NUM_DIGITS-1:0] nib_nz;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
        assign nib_nz[gi] = |disp_q[4*gi +: 4];
    end

    // A digit is lit when it or any more significant nibble is nonzero; digit 0 always lit.
    always_comb begin
        logic seen;
        seen = 1'b0;
        lit  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen   = seen | nib_nz[k];
            lit[k] = seen || (k == 0);
        end
    end
`else
    assign lit = '1;
`endif

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        idx_d        = idx_q;
        disp_d       = disp_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        nibble_d     = 4'h0;
        digit_en_d   = '1;

        tick         = (state_q == SCAN) && (presc_q == PRE_W'(SCAN_DIV - 1));
        last_digit   = (idx_q == IDX_W'(NUM_DIGITS - 1));
        wrap         = tick && last_digit;
        frame_done_d = wrap;

        case (state_q)
            EMPTY: begin
                presc_d = '0;
                if (wr_en) begin
                    disp_d  = wr_data;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    idx_d = last_digit ? '0 : idx_q + 1'b1;
                end
                // A write on the wrap tick goes straight to the display, skipping the shadow.
                if (wr_en) begin
                    if (wrap) begin
                        disp_d    = wr_data;
                        pending_d = 1'b0;
                    end else begin
                        shadow_d  = wr_data;
                        pending_d = 1'b1;
                    end
                end else if (wrap && pending_q) begin
                    disp_d    = shadow_q;
                    pending_d = 1'b0;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (state_q == SCAN) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    nibble_d      = disp_q[4*k +: 4];
                    digit_en_d[k] = ~lit[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q      <= EMPTY;
            presc_q      <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            nibble_q     <= 4'h0;
            digit_en_q   <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            nibble_q     <= nibble_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign nibble_out = nibble_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule
